interrupt_controller: RTL and testbench

- Upstream neighbour of the MCU control unit. Owns the interrupt-enable (I) flag and drives the control unit's INTERRUPT input.
- Synchronises up to 8 external interrupt request lines and detects their rising edges. Holds a pending register and a software mask register, and arbitrates a fixed priority.
- Recognises the control unit's interrupt-entry cycle as acknowledge and latches the serviced source ID, so the ISR at 0x3FF can read it through the IN port path.

---
 rtl/interrupt_controller.sv | 144 ++++++++++++++
 tb/tb_interrupt_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller
// Front end for the MCU control unit's INTERRUPT input. It synchronises up to
// eight asynchronous rising-edge request lines and latches them into a pending
// register. Sources can be masked from software. It arbitrates the unmasked
// pending sources by fixed priority, where the lowest index wins. It owns the
// interrupt-enable (I) flag. The control unit's interrupt-entry cycle
// (FLG_SHAD_LD) acts as the acknowledge: it retires the winning source and
// latches that source's ID, so the ISR can read it back.
//
// Ports
//   CLK, RESET     system clock; synchronous active-high reset
//   IRQ            external request lines (async, rising-edge sensitive)
//   I_SET, I_CLR   set / clear the I flag (clear wins)
//   FLG_SHAD_LD    interrupt-entry strobe from the control unit (acknowledge)
//   IO_STRB        OUT strobe; with PORT_ID/OUT_PORT it writes MASK or clears PEND
//   INTERRUPT      request to the control unit (registered state only)
//   I_FLAG         interrupt-enable flag
//   PEND, MASK     pending and mask registers (MASK bit 1 = enabled)
//   ACTIVE_ID      source accepted at the most recent real acknowledge
//   ACTIVE_VALID   set by the first real acknowledge after reset
module interrupt_controller #(
  parameter int unsigned NUM_SRC   = 4,
  parameter logic [7:0]  MASK_PORT = 8'h30,
  parameter logic [7:0]  CLR_PORT  = 8'h31
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] IRQ,
  input  logic               I_SET,
  input  logic               I_CLR,
  input  logic               FLG_SHAD_LD,
  input  logic               IO_STRB,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  output logic               INTERRUPT,
  output logic               I_FLAG,
  output logic [NUM_SRC-1:0] PEND,
  output logic [NUM_SRC-1:0] MASK,
  output logic [2:0]         ACTIVE_ID,
  output logic               ACTIVE_VALID
);

  // Synchroniser stages (s1, s2) and the edge-history stage (s3).
  logic [NUM_SRC-1:0] r_s1;
  logic [NUM_SRC-1:0] r_s2;
  logic [NUM_SRC-1:0] r_s3;

  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_mask;
  logic               r_iflag;
  logic [2:0]         r_active_id;
  logic               r_active_valid;

  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_elig;
  logic               w_any;
  logic [NUM_SRC-1:0] w_win_onehot;
  logic [2:0]         w_win_id;
  logic               w_ack;
  logic [NUM_SRC-1:0] w_ack_clr;
  logic               w_mask_wr;
  logic               w_clr_wr;
  logic [NUM_SRC-1:0] w_port_clr;
  logic [NUM_SRC-1:0] w_pend_nxt;
  logic               w_unused_out;

  // Detect a rising edge after the synchronised level has settled in s2.
  assign w_edge = r_s2 & ~r_s3;

  assign w_elig = r_pend & r_mask;
  assign w_any  = |w_elig;

  // Two's-complement trick: this keeps only the lowest set bit, which is the
  // fixed-priority winner as a one-hot vector.
  assign w_win_onehot = w_elig & (~w_elig + 1'b1);

  // Scan from the highest index down to the lowest. The lowest eligible index
  // is assigned last, so it is the one that remains.
  always_comb begin
    w_win_id = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_elig[NUM_SRC-1-i]) begin
        w_win_id = 3'(NUM_SRC - 1 - i);
      end
    end
  end

  // An acknowledge with nothing eligible is spurious and changes no state.
  assign w_ack     = FLG_SHAD_LD & w_any;
  assign w_ack_clr = w_ack ? w_win_onehot : '0;

  assign w_mask_wr  = IO_STRB && (PORT_ID == MASK_PORT);
  assign w_clr_wr   = IO_STRB && (PORT_ID == CLR_PORT);
  assign w_port_clr = w_clr_wr ? OUT_PORT[NUM_SRC-1:0] : '0;

  // A new edge always beats a clear from the acknowledge or from a port write.
  assign w_pend_nxt = (r_pend & ~(w_ack_clr | w_port_clr)) | w_edge;

  // OUT_PORT bits above NUM_SRC are unused.
  assign w_unused_out = &{1'b0, OUT_PORT};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1           <= '0;
      r_s2           <= '0;
      r_s3           <= '0;
      r_pend         <= '0;
      r_mask         <= '0;
      r_iflag        <= 1'b0;
      r_active_id    <= '0;
      r_active_valid <= 1'b0;
    end else begin
      r_s1   <= IRQ;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_pend <= w_pend_nxt;

      if (w_mask_wr) begin
        r_mask <= OUT_PORT[NUM_SRC-1:0];
      end

      if (I_CLR) begin
        r_iflag <= 1'b0;
      end else if (I_SET) begin
        r_iflag <= 1'b1;
      end

      if (w_ack) begin
        r_active_id    <= w_win_id;
        r_active_valid <= 1'b1;
      end
    end
  end

  // The request is built from registered state only, so no input reaches it
  // combinationally.
  assign INTERRUPT    = r_iflag & w_any;
  assign I_FLAG       = r_iflag;
  assign PEND         = r_pend;
  assign MASK         = r_mask;
  assign ACTIVE_ID    = r_active_id;
  assign ACTIVE_VALID = r_active_valid;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [N-1:0] IRQ = '0;
  logic         I_SET = 1'b0;
  logic         I_CLR = 1'b0;
  logic         FLG_SHAD_LD = 1'b0;
  logic         IO_STRB = 1'b0;
  logic [7:0]   PORT_ID = '0;
  logic [7:0]   OUT_PORT = '0;
  logic         INTERRUPT;
  logic         I_FLAG;
  logic [N-1:0] PEND;
  logic [N-1:0] MASK;
  logic [2:0]   ACTIVE_ID;
  logic         ACTIVE_VALID;

  int n_checks = 0;
  int n_errors = 0;

  interrupt_controller #(
    .NUM_SRC(N),
    .MASK_PORT(8'h30),
    .CLR_PORT(8'h31)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .IRQ(IRQ),
    .I_SET(I_SET),
    .I_CLR(I_CLR),
    .FLG_SHAD_LD(FLG_SHAD_LD),
    .IO_STRB(IO_STRB),
    .PORT_ID(PORT_ID),
    .OUT_PORT(OUT_PORT),
    .INTERRUPT(INTERRUPT),
    .I_FLAG(I_FLAG),
    .PEND(PEND),
    .MASK(MASK),
    .ACTIVE_ID(ACTIVE_ID),
    .ACTIVE_VALID(ACTIVE_VALID)
  );

  always #5 CLK = ~CLK;

  // Reference model. samples[k] is the IRQ value that was sampled k+1 edges
  // ago. A request becomes pending when the line was seen high two edges ago
  // and low three edges ago.
  logic [N-1:0] samples[3];
  logic [N-1:0] m_pend;
  logic [N-1:0] m_mask;
  bit           m_if;
  bit           m_valid;
  int           m_id;
  bit           m_live = 0;

  task automatic model_step();
    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic [N-1:0] elig;
    int           winner;
    if (RESET) begin
      for (int k = 0; k < 3; k++) samples[k] = '0;
      m_pend = '0; m_mask = '0; m_if = 0; m_valid = 0; m_id = 0;
      m_live = 1;
    end else begin
      rise = samples[1] & ~samples[2];
      elig = m_pend & m_mask;
      clr  = '0;
      if (FLG_SHAD_LD && elig != '0) begin
        winner = -1;
        for (int i = 0; i < N; i++)
          if (winner < 0 && elig[i]) winner = i;
        m_id    = winner;
        m_valid = 1;
        clr[winner] = 1'b1;
      end
      if (IO_STRB && PORT_ID == 8'h31) clr = clr | OUT_PORT[N-1:0];
      m_pend = (m_pend & ~clr) | rise;
      if (IO_STRB && PORT_ID == 8'h30) m_mask = OUT_PORT[N-1:0];
      if (I_CLR) m_if = 0;
      else if (I_SET) m_if = 1;
      samples[2] = samples[1];
      samples[1] = samples[0];
      samples[0] = IRQ;
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, taken midway between clock edges.
  initial forever begin
    @(negedge CLK);
    if (m_live) begin
      chk("pend", 32'(PEND), 32'(m_pend));
      chk("mask", 32'(MASK), 32'(m_mask));
      chk("iflag", 32'(I_FLAG), 32'(m_if));
      chk("interrupt", 32'(INTERRUPT), 32'(m_if && ((m_pend & m_mask) != '0)));
      chk("active_valid", 32'(ACTIVE_VALID), 32'(m_valid));
      chk("active_id", 32'(ACTIVE_ID), 32'(m_id));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic out_wr(input logic [7:0] port, input logic [7:0] data);
    IO_STRB = 1'b1; PORT_ID = port; OUT_PORT = data;
    tick();
    IO_STRB = 1'b0; PORT_ID = '0; OUT_PORT = '0;
  endtask

  task automatic ack();
    FLG_SHAD_LD = 1'b1; I_CLR = 1'b1;
    tick();
    FLG_SHAD_LD = 1'b0; I_CLR = 1'b0;
  endtask

  initial begin
    // Reset state.
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    chk("rst_pend", 32'(PEND), 0);
    chk("rst_mask", 32'(MASK), 0);
    chk("rst_iflag", 32'(I_FLAG), 0);
    chk("rst_int", 32'(INTERRUPT), 0);
    chk("rst_valid", 32'(ACTIVE_VALID), 0);

    // Single source: rising edge to pending to acknowledge.
    out_wr(8'h30, 8'h0F);
    chk("mask_wr", 32'(MASK), 32'hF);
    I_SET = 1'b1; tick(); I_SET = 1'b0;
    chk("iset", 32'(I_FLAG), 1);
    IRQ = 4'b0100;
    tick(); chk("lat_e0", 32'(PEND), 0);
    tick(); chk("lat_e1", 32'(PEND), 0);
    tick(); chk("lat_e2", 32'(PEND), 32'h4);
    chk("t1_int", 32'(INTERRUPT), 1);
    ack();
    chk("t1_id", 32'(ACTIVE_ID), 2);
    chk("t1_valid", 32'(ACTIVE_VALID), 1);
    chk("t1_pend", 32'(PEND), 0);
    chk("t1_int0", 32'(INTERRUPT), 0);
    IRQ = '0;

    // Two simultaneous sources are serviced in priority order.
    IRQ = 4'b1010;
    I_SET = 1'b1; tick(); I_SET = 1'b0;
    tick(); tick();
    chk("t2_pend", 32'(PEND), 32'hA);
    chk("t2_int", 32'(INTERRUPT), 1);
    ack();
    chk("t2_id1", 32'(ACTIVE_ID), 1);
    chk("t2_pend1", 32'(PEND), 32'h8);
    chk("t2_int0", 32'(INTERRUPT), 0);
    I_SET = 1'b1; tick(); I_SET = 1'b0;
    chk("t2_retie", 32'(INTERRUPT), 1);
    ack();
    chk("t2_id3", 32'(ACTIVE_ID), 3);
    chk("t2_pend0", 32'(PEND), 0);

    // A held line is pending only once; I_CLR beats I_SET.
    IRQ = 4'b0001;
    for (int i = 0; i < 20; i++) tick();
    chk("held_pend", 32'(PEND), 32'h1);
    I_SET = 1'b1; I_CLR = 1'b1; tick(); I_SET = 1'b0; I_CLR = 1'b0;
    chk("set_clr", 32'(I_FLAG), 0);
    chk("noif_int", 32'(INTERRUPT), 0);

    // A new edge on source 0 arrives in the same cycle as the acknowledge of source 0.
    IRQ = '0; tick(); tick(); tick();
    IRQ = 4'b0001; tick(); tick();
    ack();
    chk("t5_id", 32'(ACTIVE_ID), 0);
    chk("t5_pend", 32'(PEND), 32'h1);
    // A clear-port write coincides with a new edge.
    IRQ = '0; tick(); tick(); tick();
    IRQ = 4'b0001; tick(); tick();
    out_wr(8'h31, 8'hFF);
    chk("t5_clr", 32'(PEND), 32'h1);
    // A masked source stays pending until its mask bit is set.
    out_wr(8'h30, 8'h0E);
    I_SET = 1'b1; tick(); I_SET = 1'b0;
    chk("t3_masked", 32'(INTERRUPT), 0);
    out_wr(8'h30, 8'h01);
    chk("t3_unmask", 32'(INTERRUPT), 1);
    out_wr(8'h31, 8'h01);
    chk("t3_clr", 32'(PEND), 0);
    chk("t3_int0", 32'(INTERRUPT), 0);

    // Reset with a line held high yields exactly one edge after release.
    IRQ = 4'b0010;
    RESET = 1'b1; tick();
    chk("t6_pend", 32'(PEND), 0);
    chk("t6_mask", 32'(MASK), 0);
    chk("t6_if", 32'(I_FLAG), 0);
    chk("t6_valid", 32'(ACTIVE_VALID), 0);
    RESET = 1'b0;
    tick(); tick();
    chk("t6_e1", 32'(PEND), 0);
    tick();
    chk("t6_e2", 32'(PEND), 32'h2);

    // Randomised traffic, checked against the model every cycle.
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0] tog;
      int sel;
      tog = '0;
      for (int b = 0; b < N; b++) tog[b] = ($urandom_range(0, 7) == 0);
      IRQ = IRQ ^ tog;
      I_SET = ($urandom_range(0, 9) == 0);
      FLG_SHAD_LD = ($urandom_range(0, 7) == 0);
      I_CLR = FLG_SHAD_LD ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 11) == 0);
      IO_STRB = ($urandom_range(0, 5) == 0);
      sel = $urandom_range(0, 2);
      PORT_ID = (sel == 0) ? 8'h30 : (sel == 1) ? 8'h31 : 8'($urandom_range(0, 255));
      OUT_PORT = 8'($urandom_range(0, 255));
      RESET = ($urandom_range(0, 499) == 0);
      tick();
    end
    RESET = 1'b0; IO_STRB = 1'b0; FLG_SHAD_LD = 1'b0; I_SET = 1'b0; I_CLR = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
